// File: rtl/mat_stream_transpose.sv
// -----------------------------------------------------------------------------
// mat_stream_transpose
//
// Streaming matrix transposer. Accepts an M x N matrix of 32-bit words one
// element per beat in row-major order, buffers the whole matrix, then emits
// the N x M transpose one element per beat (column-major order of the input).
// The fill and drain phases never overlap.
//
// Parameters:
//   M          rows of the input matrix (>= 1)
//   N          columns of the input matrix (>= 1)
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   producer offers in_data
//   in_ready   block accepts in_data (FILL only, low while rst is high)
//   in_data    input element, row-major order
//   out_valid  out_data holds a valid element (DRAIN only)
//   out_ready  consumer accepts out_data
//   out_data   transposed element, zero when out_valid is low
//   busy       high while draining
//   out_last   (optional) marks the final element of a transposed matrix
//
// Optional feature: define MAT_STREAM_TRANSPOSE_LAST_EN to add out_last.
// -----------------------------------------------------------------------------
module mat_stream_transpose #(
    parameter int unsigned M = 2,
    parameter int unsigned N = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
`ifdef MAT_STREAM_TRANSPOSE_LAST_EN
    ,
    output logic        out_last
`endif
);

    // Counter widths; a 1-deep dimension still gets a 1-bit counter.
    localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [RW-1:0] RMax = RW'(M - 1);
    localparam logic [CW-1:0] CMax = CW'(N - 1);

    localparam logic [0:0] StFill  = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    logic [0:0]    state_q, state_d;
    // Fill position (row r, column c) of the next input element.
    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    // Drain position: j walks columns (outer), i walks rows (inner).
    logic [RW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;

    logic [31:0]   mem_q [M][N];
    logic [31:0]   rd_data;

    logic          in_hs;
    logic          out_hs;

    // Outputs are forced idle while rst is high, even before the reset edge.
    assign in_ready  = (state_q == StFill) && !rst;
    assign out_valid = (state_q == StDrain) && !rst;
    assign busy      = out_valid;
    assign out_data  = out_valid ? rd_data : '0;

`ifdef MAT_STREAM_TRANSPOSE_LAST_EN
    assign out_last  = out_valid && (i_q == RMax) && (j_q == CMax);
`endif

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            StFill: begin
                if (in_hs) begin
                    if (c_q == CMax) begin
                        c_d = '0;
                        if (r_q == RMax) begin
                            r_d     = '0;
                            state_d = StDrain;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_hs) begin
                    if (i_q == RMax) begin
                        i_d = '0;
                        if (j_q == CMax) begin
                            j_d     = '0;
                            state_d = StFill;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            r_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Element storage: written at the fill position, cleared on reset so an
    // aborted matrix leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(M); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (in_hs) begin
            for (int r = 0; r < int'(M); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    if ((r_q == RW'(r)) && (c_q == CW'(c))) begin
                        mem_q[r][c] <= in_data;
                    end
                end
            end
        end
    end

    // Read mux: element at (row i, column j).
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < int'(M); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                if ((i_q == RW'(r)) && (j_q == CW'(c))) begin
                    rd_data = mem_q[r][c];
                end
            end
        end
    end

endmodule
